// File: rtl/noc_buffered_switch.sv
// Input-buffered 3x3 torus NoC router: per-input FIFOs, XY routing, and a
// round-robin arbiter plus one output register per output port.
module noc_buffered_switch #(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int fifo_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid_l,
  input  logic                   i_valid_b,
  input  logic                   i_valid_pe,
  input  logic [total_width-1:0] i_data_l,
  input  logic [total_width-1:0] i_data_b,
  input  logic [total_width-1:0] i_data_pe,
  output logic                   o_ready_l,
  output logic                   o_ready_b,
  output logic                   o_ready_pe,
  output logic                   o_valid_r,
  output logic                   o_valid_t,
  output logic                   o_valid_pe,
  output logic [total_width-1:0] o_data_r,
  output logic [total_width-1:0] o_data_t,
  output logic [total_width-1:0] o_data_pe,
  input  logic                   i_ready_r,
  input  logic                   i_ready_t,
  input  logic                   i_ready_pe
);

  localparam int AW = $clog2(fifo_depth);
  localparam int AD = x_size + y_size;
  localparam logic [x_size-1:0] X_ID = x_size'(x_coord);
  localparam logic [y_size-1:0] Y_ID = y_size'(y_coord);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(fifo_depth);
  localparam logic [1:0] OUT_R  = 2'd0;
  localparam logic [1:0] OUT_T  = 2'd1;
  localparam logic [1:0] OUT_PE = 2'd2;

  // Inputs indexed 0=left, 1=bottom, 2=pe; outputs 0=right, 1=top, 2=pe.
  logic                   in_vld   [3];
  logic [total_width-1:0] in_data  [3];
  logic                   in_rdy   [3];
  logic                   out_rdy  [3];

  logic [total_width-1:0] mem      [3][fifo_depth];
  logic [AW-1:0]          wr_ptr   [3];
  logic [AW-1:0]          rd_ptr   [3];
  logic [AW:0]            cnt      [3];
  logic [total_width-1:0] head     [3];
  logic [1:0]             route    [3];
  logic                   empty    [3];
  logic                   push     [3];
  logic                   pop      [3];

  logic                   can_load [3];
  logic                   gnt_vld  [3];
  logic [1:0]             gnt_idx  [3];
  logic [1:0]             rr_ptr   [3];
  logic                   vld_p1   [3];
  logic [total_width-1:0] data_p1  [3];

  function automatic logic [1:0] xy_route(input logic [AD-1:0] addr);
    if (addr[x_size-1:0] != X_ID) return OUT_R;
    if (addr[AD-1:x_size] != Y_ID) return OUT_T;
    return OUT_PE;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] winner);
    return (winner == 2'd2) ? 2'd0 : winner + 2'd1;
  endfunction

  assign in_vld[0]  = i_valid_l;
  assign in_vld[1]  = i_valid_b;
  assign in_vld[2]  = i_valid_pe;
  assign in_data[0] = i_data_l;
  assign in_data[1] = i_data_b;
  assign in_data[2] = i_data_pe;
  assign out_rdy[0] = i_ready_r;
  assign out_rdy[1] = i_ready_t;
  assign out_rdy[2] = i_ready_pe;

  assign o_ready_l  = in_rdy[0];
  assign o_ready_b  = in_rdy[1];
  assign o_ready_pe = in_rdy[2];
  assign o_valid_r  = vld_p1[0];
  assign o_valid_t  = vld_p1[1];
  assign o_valid_pe = vld_p1[2];
  assign o_data_r   = data_p1[0];
  assign o_data_t   = data_p1[1];
  assign o_data_pe  = data_p1[2];

  // Stage p0: FIFO head, route and push qualification
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_rdy[i] = (cnt[i] != FULL_CNT) && !rst;
      push[i]   = in_vld[i] && in_rdy[i];
      empty[i]  = (cnt[i] == '0);
      head[i]   = mem[i][rd_ptr[i]];
      route[i]  = xy_route(head[i][AD-1:0]);
    end
  end

  always_comb begin
    logic [2:0] cand;
    cand = '0;
    for (int o = 0; o < 3; o++) begin
      can_load[o] = !vld_p1[o] || out_rdy[o];
      gnt_vld[o]  = 1'b0;
      gnt_idx[o]  = 2'd0;
      for (int k = 0; k < 3; k++) begin
        cand = {1'b0, rr_ptr[o]} + 3'(k);
        if (cand >= 3'd3) cand = cand - 3'd3;
        if (!gnt_vld[o] && can_load[o] && !empty[cand[1:0]] &&
            route[cand[1:0]] == 2'(o)) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand[1:0];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      pop[i] = 1'b0;
      for (int o = 0; o < 3; o++)
        if (gnt_vld[o] && gnt_idx[o] == 2'(i)) pop[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + (AW+1)'(1);
        else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - (AW+1)'(1);
      end
    end
  end

  // Payload storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
  end

  // Stage p1: output registers and arbiter pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < 3; o++) begin
        vld_p1[o]  <= 1'b0;
        data_p1[o] <= '0;
        rr_ptr[o]  <= 2'd0;
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (can_load[o]) begin
          vld_p1[o] <= gnt_vld[o];
          if (gnt_vld[o]) begin
            data_p1[o] <= head[gnt_idx[o]];
            rr_ptr[o]  <= rr_next(gnt_idx[o]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_buffered_switch.sv
// Bench for noc_buffered_switch at node (0,0): directed scenarios plus a
// randomised mix, all checked against a queue-based model of the router.
module tb_noc_buffered_switch;
  localparam int DW = 16, XS = 1, YS = 1, TW = XS + YS + DW, DEPTH = 4;
  localparam int XC = 0, YC = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          iv  [3];
  logic [TW-1:0] idat[3];
  logic          ir  [3];
  logic o_ready_l, o_ready_b, o_ready_pe;
  logic o_valid_r, o_valid_t, o_valid_pe;
  logic [TW-1:0] o_data_r, o_data_t, o_data_pe;
  logic          ov [3];
  logic          orr[3];
  logic [TW-1:0] od [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt[3];

  // Model state: input queues, output registers, arbiter pointers.
  logic [TW-1:0] mq[3][$];
  bit            mo_v[3];
  logic [TW-1:0] mo_d[3];
  int            mptr[3];
  bit            acc[3];
  int            acc_total, del_total;
  int            last_seq[3][3];
  bit            seen[3][16384];

  noc_buffered_switch #(.x_coord(XC), .y_coord(YC), .data_width(DW),
                        .x_size(XS), .y_size(YS), .fifo_depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_valid_l(iv[0]), .i_valid_b(iv[1]), .i_valid_pe(iv[2]),
    .i_data_l(idat[0]), .i_data_b(idat[1]), .i_data_pe(idat[2]),
    .o_ready_l(o_ready_l), .o_ready_b(o_ready_b), .o_ready_pe(o_ready_pe),
    .o_valid_r(o_valid_r), .o_valid_t(o_valid_t), .o_valid_pe(o_valid_pe),
    .o_data_r(o_data_r), .o_data_t(o_data_t), .o_data_pe(o_data_pe),
    .i_ready_r(ir[0]), .i_ready_t(ir[1]), .i_ready_pe(ir[2])
  );

  assign ov[0] = o_valid_r;  assign ov[1] = o_valid_t;  assign ov[2] = o_valid_pe;
  assign od[0] = o_data_r;   assign od[1] = o_data_t;   assign od[2] = o_data_pe;
  assign orr[0] = o_ready_l; assign orr[1] = o_ready_b; assign orr[2] = o_ready_pe;

  always #5 clk = ~clk;

  function automatic int route_of(input logic [TW-1:0] f);
    if (int'(f[0]) != XC) return 0;
    if (int'(f[1]) != YC) return 1;
    return 2;
  endfunction

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic note_delivery(input int o, input logic [TW-1:0] f);
    int src, seq;
    src = int'(f[TW-1:TW-2]);
    seq = int'(f[TW-3:2]);
    chk($sformatf("route%0d", o), route_of(f), o);
    chk("src_range", src < 3, 1);
    if (src < 3) begin
      chk("per_input_order", seq > last_seq[o][src], 1);
      chk("exactly_once", seen[src][seq], 0);
      seen[src][seq] = 1'b1;
      last_seq[o][src] = seq;
    end
    del_total++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        mo_v[i] = 1'b0;
        mo_d[i] = '0;
        mptr[i] = 0;
        acc[i]  = 1'b0;
        for (int o = 0; o < 3; o++) last_seq[o][i] = -1;
      end
      acc_total = 0;
      del_total = 0;
    end else begin : step
      int win[3];
      int s;
      for (int i = 0; i < 3; i++) acc[i] = iv[i] && (mq[i].size() < DEPTH);
      for (int o = 0; o < 3; o++) if (mo_v[o] && ir[o]) note_delivery(o, mo_d[o]);
      for (int o = 0; o < 3; o++) begin
        win[o] = -1;
        if (!mo_v[o] || ir[o])
          for (int k = 0; k < 3; k++) begin
            s = (mptr[o] + k) % 3;
            if (win[o] < 0 && mq[s].size() != 0 && route_of(mq[s][0]) == o) win[o] = s;
          end
      end
      for (int o = 0; o < 3; o++) begin
        if (!mo_v[o] || ir[o]) begin
          if (win[o] >= 0) begin
            mo_d[o] = mq[win[o]].pop_front();
            mo_v[o] = 1'b1;
            mptr[o] = (win[o] + 1) % 3;
          end else begin
            mo_v[o] = 1'b0;
          end
        end
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin
          mq[i].push_back(idat[i]);
          acc_total++;
        end
    end
  end

  always @(negedge clk) begin
    for (int o = 0; o < 3; o++) begin
      if (rst) begin
        chk($sformatf("reset_valid%0d", o), ov[o], 0);
        chk($sformatf("reset_data%0d", o), od[o], 0);
        chk($sformatf("reset_ready%0d", o), orr[o], 0);
      end else begin
        chk($sformatf("valid%0d", o), ov[o], mo_v[o]);
        if (mo_v[o]) chk($sformatf("data%0d", o), od[o], mo_d[o]);
        chk($sformatf("ready%0d", o), orr[o], mq[o].size() < DEPTH);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (iv[i] && acc[i]) iv[i] = 1'b0;
  endtask

  task automatic offer(input int i, input bit dx, input bit dy);
    if (!iv[i]) begin
      idat[i] = {2'(i), 14'(cnt[i]), dy, dx};
      cnt[i]++;
      iv[i] = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] f, lf;
    int first, idx;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; idat[i] = '0; ir[i] = 1'b1; cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_reset_ready_l", o_ready_l, 1);
    chk("post_reset_ready_pe", o_ready_pe, 1);
    chk("post_reset_valid_r", o_valid_r, 0);
    chk("post_reset_data_r", o_data_r, 0);

    // PE flit heading east: visible two edges after acceptance
    offer(2, 1'b1, 1'b0);
    f = idat[2];
    tick();
    chk("lat_edge1_valid_r", o_valid_r, 0);
    tick();
    chk("lat_edge2_valid_r", o_valid_r, 1);
    chk("lat_edge2_data_r", o_data_r, f);
    chk("lat_idle_t", o_valid_t, 0);
    chk("lat_idle_pe", o_valid_pe, 0);
    tick();
    chk("lat_drained_r", o_valid_r, 0);

    // Backpressure on right: 1 in output register + 4 in the left FIFO
    ir[0] = 1'b0;
    first = cnt[0];
    for (int k = 0; k < 5; k++) begin
      offer(0, 1'b1, 1'b0);
      tick();
    end
    repeat (2) tick();
    chk("bp_ready_l_low", o_ready_l, 0);
    chk("bp_valid_r", o_valid_r, 1);
    chk("bp_head_seq", o_data_r[TW-3:2], first);
    tick();
    chk("bp_stable_seq", o_data_r[TW-3:2], first);
    ir[0] = 1'b1;
    tick();
    chk("bp_ready_l_back", o_ready_l, 1);
    chk("bp_drain_seq1", o_data_r[TW-3:2], first + 1);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk($sformatf("bp_drain_seq%0d", k), o_data_r[TW-3:2], first + k);
    end
    tick();
    chk("bp_drained", o_valid_r, 0);

    // Left->pe and bottom->right side by side, then with pe stalled
    offer(0, 1'b0, 1'b0);
    offer(1, 1'b1, 1'b0);
    tick();
    tick();
    chk("par_valid_pe", o_valid_pe, 1);
    chk("par_valid_r", o_valid_r, 1);
    tick();
    ir[2] = 1'b0;
    offer(0, 1'b0, 1'b0);
    lf = idat[0];
    offer(1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k >= 1) begin
        chk("stall_valid_pe", o_valid_pe, 1);
        chk("stall_data_pe", o_data_pe, lf);
        chk("flow_valid_r", o_valid_r, 1);
      end
      offer(1, 1'b1, 1'b0);
    end
    ir[2] = 1'b1;
    repeat (6) tick();

    // Reset mid-traffic with every output stalled and FIFOs holding 2
    for (int o = 0; o < 3; o++) ir[o] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(0, 1'b1, 1'b0);
      offer(1, 1'b0, 1'b1);
      offer(2, 1'b0, 1'b0);
      tick();
    end
    tick();
    chk("pre_rst_valid_r", o_valid_r, 1);
    chk("pre_rst_valid_t", o_valid_t, 1);
    chk("pre_rst_valid_pe", o_valid_pe, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid_r", o_valid_r, 0);
    chk("async_rst_valid_t", o_valid_t, 0);
    chk("async_rst_valid_pe", o_valid_pe, 0);
    chk("async_rst_ready_l", o_ready_l, 0);
    chk("async_rst_ready_b", o_ready_b, 0);
    chk("async_rst_data_t", o_data_t, 0);
    for (int o = 0; o < 3; o++) ir[o] = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // All inputs to top: arbiter restarts at left and rotates each cycle
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      offer(0, 1'b0, 1'b1);
      offer(1, 1'b0, 1'b1);
      offer(2, 1'b0, 1'b1);
      tick();
      if (o_valid_t) begin
        chk($sformatf("rr_src%0d", idx), o_data_t[TW-1:TW-2], idx % 3);
        idx++;
      end
    end
    chk("rr_one_per_cycle", idx, 13);
    repeat (20) tick();

    // Randomised traffic over the 2x2 destination space
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 99) < 55)
          offer(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int o = 0; o < 3; o++) ir[o] = ($urandom_range(0, 99) < 70);
      tick();
    end
    for (int o = 0; o < 3; o++) ir[o] = 1'b1;
    repeat (40) tick();
    chk("final_all_delivered", del_total, acc_total);
    chk("final_traffic_seen", acc_total > 500, 1);
    chk("final_model_empty", mq[0].size() + mq[1].size() + mq[2].size(), 0);
    chk("final_idle_r", o_valid_r, 0);
    chk("final_idle_t", o_valid_t, 0);
    chk("final_idle_pe", o_valid_pe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
